// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states and SPI mode encodings for the SPI receive master.
package spi_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, GAP = 2'd3} state_e;
   localparam int CPOL = 1;
   localparam int CPHA = 0;
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;
endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: divides clk into sck half-periods and flags leading/trailing/final edges.
module spi_sck_gen #(
   parameter int FRAME_W = 16,
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic cpol,
   output logic sck,
   output logic lead_stb,
   output logic trail_stb,
   output logic done_stb
);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int HW = $clog2(2 * FRAME_W);
   logic [DW-1:0] div_cnt;
   logic [HW-1:0] half_cnt;
   logic bnd;
   assign bnd       = en && div_cnt == DW'(CLK_DIV - 1);
   assign lead_stb  = bnd && !half_cnt[0];
   assign trail_stb = bnd && half_cnt[0];
   assign done_stb  = bnd && half_cnt == HW'(2 * FRAME_W - 1);
   // Strobes coincide with the clk edge that registers the sck toggle.
   always_ff @(posedge clk)
      if (rst) begin
         div_cnt  <= '0;
         half_cnt <= '0;
         sck      <= 1'b0;
      end else if (!en) begin
         div_cnt  <= '0;
         half_cnt <= '0;
         sck      <= cpol;
      end else begin
         div_cnt  <= bnd ? '0 : div_cnt + 1'b1;
         half_cnt <= bnd ? half_cnt + 1'b1 : half_cnt;
         sck      <= bnd ? ~sck : sck;
      end
endmodule

// File: rtl/spi_rx_master.sv
// spi_rx_master: SPI receive master with runtime mode, multiple chip selects,
// continuous conversion and a valid/ready output register with overrun detection.
module spi_rx_master
   import spi_pkg::*;
#(
   parameter int FRAME_W  = 16,
   parameter int DATA_W   = 8,
   parameter int DATA_LSB = 5,
   parameter int CLK_DIV  = 4,
   parameter int N_CS     = 1,
   parameter int CS_GAP   = 2
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start_i,
   input  logic                                     cont_i,
   input  logic [1:0]                               mode_i,
   input  logic [$clog2(N_CS > 1 ? N_CS : 2)-1:0]   cs_sel_i,
   input  logic                                     sdo_i,
   output logic                                     sck_o,
   output logic [N_CS-1:0]                          cs_o,
   output logic                                     busy_o,
   output logic [FRAME_W-1:0]                       frame_o,
   output logic [DATA_W-1:0]                        data_o,
   output logic                                     valid_o,
   input  logic                                     ready_i,
   output logic                                     overrun_o
);
   localparam int CSW = $clog2(N_CS > 1 ? N_CS : 2);
   localparam int CW  = $clog2(CLK_DIV + CS_GAP + 1) + 1;
   if (FRAME_W < 2 || DATA_LSB + DATA_W > FRAME_W || CLK_DIV < 1 || N_CS < 1 || CS_GAP < 1) begin : g_bad_cfg
      $error("spi_rx_master: illegal parameter combination");
   end
   state_e state;
   logic [CW-1:0] cnt;
   logic [1:0] mode_q;
   logic [CSW-1:0] sel_q;
   logic cont_q;
   logic [FRAME_W-1:0] sh;
   logic [N_CS-1:0] dec_i, dec_q;
   logic go, setup_end, load, gap_end, again, lead, trail, done, smp;
   assign go        = state == IDLE && start_i;
   assign setup_end = state == SETUP && cnt == CW'(CLK_DIV - 1);
   assign load      = state == GAP && cnt == '0;
   assign gap_end   = state == GAP && cnt == CW'(CS_GAP);
   assign again     = gap_end && cont_q && cont_i;
   assign smp       = mode_q[CPHA] ? trail : lead;
   assign busy_o    = state != IDLE;
   assign data_o    = frame_o[DATA_LSB +: DATA_W];
   // Out-of-range selects decode to no line at all.
   always_comb begin
      dec_i = '0;
      dec_q = '0;
      for (int i = 0; i < N_CS; i++) begin
         dec_i[i] = cs_sel_i == CSW'(i);
         dec_q[i] = sel_q == CSW'(i);
      end
   end
   spi_sck_gen #(.FRAME_W(FRAME_W), .CLK_DIV(CLK_DIV)) u_sck (
      .clk      (clk),
      .rst      (rst),
      .en       (state == SHIFT),
      .cpol     (go ? mode_i[CPOL] : mode_q[CPOL]),
      .sck      (sck_o),
      .lead_stb (lead),
      .trail_stb(trail),
      .done_stb (done)
   );
   always_ff @(posedge clk)
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         mode_q    <= '0;
         sel_q     <= '0;
         cont_q    <= 1'b0;
         sh        <= '0;
         cs_o      <= '1;
         frame_o   <= '0;
         valid_o   <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         state     <= go ? SETUP : setup_end ? SHIFT : done ? GAP : gap_end ? (again ? SETUP : IDLE) : state;
         cnt       <= (state == IDLE || state == SHIFT || setup_end || gap_end) ? '0 : cnt + 1'b1;
         if (go) begin
            mode_q <= mode_i;
            sel_q  <= cs_sel_i;
            cont_q <= cont_i;
            cs_o   <= ~dec_i;
         end
         if (smp) sh <= {sh[FRAME_W-2:0], sdo_i};
         if (load) begin
            cs_o    <= '1;
            frame_o <= sh;
         end
         if (again) cs_o <= ~dec_q;
         valid_o   <= load || (valid_o && !ready_i);
         overrun_o <= load && valid_o && !ready_i;
      end
endmodule

// File: tb/tb_spi_rx_master.sv
// tb_spi_rx_master: table-driven frames against an SPI device model, with a scoreboard
// of expected frames and hand-written continuous, coincident-ready and reset sequences.
module tb_spi_rx_master;
   import spi_pkg::*;
   typedef struct {
      logic [1:0]  mode;
      logic [1:0]  sel;
      logic [15:0] pat;
      logic [7:0]  data;
   } vec_t;
   typedef struct {
      logic [15:0] f;
      logic [7:0]  d;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, cont_i = 1'b0, sdo_i = 1'b1, ready_i = 1'b0;
   logic [1:0] mode_i = 2'b00, cs_sel_i = 2'd0;
   logic sck_o, busy_o, valid_o, overrun_o;
   logic [3:0] cs_o;
   logic [15:0] frame_o;
   logic [7:0] data_o;
   logic start3 = 1'b0;
   logic sck3, busy3, valid3, ovr3;
   logic [2:0] cs3;
   logic [15:0] frame3;
   logic [7:0] data3;
   int checks = 0, failures = 0, cyc = 0;
   exp_t exp_q[$];
   logic [15:0] dev_q[$];
   logic [15:0] cur = '0;
   logic [1:0] dev_mode = MODE0;
   int idx = 0;
   logic prev_sck = 1'b0;
   logic [3:0] pcs = '1;
   logic pv = 1'b0;
   logic [15:0] pf = '0;
   int falls[4] = '{0, 0, 0, 0};
   int cs_fall_cyc = 0, cs_rise_cyc = 0, loads = 0, last_load_cyc = 0, ovr_cnt = 0;
   logic cs3_low = 1'b0;
   vec_t vecs[4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_rx_master #(.N_CS(4)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .cont_i(cont_i), .mode_i(mode_i),
      .cs_sel_i(cs_sel_i), .sdo_i(sdo_i), .sck_o(sck_o), .cs_o(cs_o), .busy_o(busy_o),
      .frame_o(frame_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
      .overrun_o(overrun_o)
   );
   spi_rx_master #(.N_CS(3)) u3 (
      .clk(clk), .rst(rst), .start_i(start3), .cont_i(1'b0), .mode_i(2'b00),
      .cs_sel_i(2'd3), .sdo_i(1'b1), .sck_o(sck3), .cs_o(cs3), .busy_o(busy3),
      .frame_o(frame3), .data_o(data3), .valid_o(valid3), .ready_i(1'b1),
      .overrun_o(ovr3)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Device model: presents the MSB when selected, then shifts on the edge opposite to sampling.
   always @(negedge clk) begin
      if (rst || &cs_o) sdo_i = 1'b1;
      else if (&pcs) begin
         cur = dev_q.size() > 0 ? dev_q.pop_front() : 16'h0000;
         idx = 0;
         if (!dev_mode[CPHA]) begin
            sdo_i = cur[15];
            idx = 1;
         end
      end else if (sck_o != prev_sck && ((sck_o != dev_mode[CPOL]) == dev_mode[CPHA])) begin
         if (idx < 16) sdo_i = cur[15 - idx];
         idx++;
      end
      prev_sck = sck_o;
   end

   // Scoreboard and event monitor: a frame load shows as valid rising, a data change or an overrun.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid_o && (!pv || frame_o != pf || overrun_o)) begin
            if (exp_q.size() == 0) chk("sb_unexpected_load", 32'(frame_o), 32'hFFFF_FFFF);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sb_frame", 32'(frame_o), 32'(e.f));
               chk("sb_data", 32'(data_o), 32'(e.d));
            end
            loads++;
            last_load_cyc = cyc;
         end
         if (overrun_o) ovr_cnt++;
         for (int b = 0; b < 4; b++) begin
            if (pcs[b] && !cs_o[b]) begin
               falls[b]++;
               cs_fall_cyc = cyc;
            end
            if (!pcs[b] && cs_o[b]) cs_rise_cyc = cyc;
         end
         if (cs3 != 3'b111) cs3_low = 1'b1;
      end
      pv  = valid_o;
      pf  = frame_o;
      pcs = cs_o;
   end

   task automatic pulse_start(input logic [1:0] m, input logic [1:0] sel, input logic c, output int e0);
      @(negedge clk);
      start_i  = 1'b1;
      mode_i   = m;
      cs_sel_i = sel;
      cont_i   = c;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      e0 = cyc;
   endtask

   task automatic run_frame(input logic [1:0] m, input logic [1:0] sel, input logic [15:0] pat, input logic [7:0] d);
      int e0;
      int f0[4];
      f0 = falls;
      dev_mode = m;
      dev_q.push_back(pat);
      exp_q.push_back('{f: pat, d: d});
      pulse_start(m, sel, 1'b0, e0);
      for (int i = 0; i < 300 && !valid_o; i++) @(negedge clk);
      chk("valid_rise_cycle", 32'(cyc - e0), 32'd133);
      chk("sck_idle_gap", 32'(sck_o), 32'(m[CPOL]));
      for (int i = 0; i < 300 && busy_o; i++) @(negedge clk);
      chk("busy_fall_cycle", 32'(cyc - e0), 32'd135);
      chk("sck_idle_idle", 32'(sck_o), 32'(m[CPOL]));
      chk("cs_fall_cycle", 32'(cs_fall_cyc - e0), 32'd0);
      chk("cs_rise_cycle", 32'(cs_rise_cyc - e0), 32'd133);
      for (int b = 0; b < 4; b++)
         chk($sformatf("cs%0d_falls", b), 32'(falls[b] - f0[b]), (32'(b) == 32'(sel)) ? 32'd1 : 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, l0, o0;
      vecs[0] = '{mode: MODE0, sel: 2'd0, pat: 16'h1EE0, data: 8'hF7};
      vecs[1] = '{mode: MODE1, sel: 2'd2, pat: 16'hA55A, data: 8'h2A};
      vecs[2] = '{mode: MODE2, sel: 2'd1, pat: 16'hA55A, data: 8'h2A};
      vecs[3] = '{mode: MODE3, sel: 2'd3, pat: 16'hA55A, data: 8'h2A};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cs", 32'(cs_o), 32'hF);
      chk("rst_sck", 32'(sck_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_overrun", 32'(overrun_o), 32'd0);
      chk("rst_frame", 32'(frame_o), 32'd0);
      chk("rst_data", 32'(data_o), 32'd0);
      rst = 1'b0;
      ready_i = 1'b1;
      foreach (vecs[k]) run_frame(vecs[k].mode, vecs[k].sel, vecs[k].pat, vecs[k].data);

      // Out-of-range select on a three-device instance: no cs, frame still completes.
      @(negedge clk);
      start3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start3 = 1'b0;
      e0 = cyc;
      for (int i = 0; i < 300 && !valid3; i++) @(negedge clk);
      chk("oor_valid_cycle", 32'(cyc - e0), 32'd133);
      chk("oor_frame", 32'(frame3), 32'hFFFF);
      chk("oor_data", 32'(data3), 32'hFF);
      for (int i = 0; i < 300 && busy3; i++) @(negedge clk);
      chk("oor_busy", 32'(busy3), 32'd0);
      chk("oor_cs_never_low", 32'(cs3_low), 32'd0);
      chk("oor_sck", 32'(sck3), 32'd0);
      chk("oor_overrun", 32'(ovr3), 32'd0);

      // Continuous stream with no consumer: second load overwrites and flags overrun.
      ready_i  = 1'b0;
      dev_mode = MODE0;
      dev_q.push_back(16'h0001);
      dev_q.push_back(16'h0002);
      exp_q.push_back('{f: 16'h0001, d: 8'h00});
      exp_q.push_back('{f: 16'h0002, d: 8'h00});
      l0 = loads;
      o0 = ovr_cnt;
      pulse_start(MODE0, 2'd0, 1'b1, e0);
      for (int i = 0; i < 300 && loads == l0; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      cont_i = 1'b0;
      for (int i = 0; i < 400 && busy_o; i++) @(negedge clk);
      chk("cont_loads", 32'(loads - l0), 32'd2);
      chk("cont_second_load", 32'(last_load_cyc - e0), 32'd268);
      chk("cont_end_cycle", 32'(cyc - e0), 32'd270);
      chk("cont_overruns", 32'(ovr_cnt - o0), 32'd1);
      chk("cont_frame", 32'(frame_o), 32'h0002);
      chk("cont_valid", 32'(valid_o), 32'd1);

      // Load coincident with ready while valid is still high from the previous frame.
      o0 = ovr_cnt;
      dev_q.push_back(16'h1234);
      exp_q.push_back('{f: 16'h1234, d: 8'h91});
      pulse_start(MODE0, 2'd0, 1'b0, e0);
      for (int i = 0; i < 300 && cyc < e0 + 132; i++) @(negedge clk);
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
      chk("coinc_valid", 32'(valid_o), 32'd1);
      chk("coinc_overrun", 32'(overrun_o), 32'd0);
      chk("coinc_frame", 32'(frame_o), 32'h1234);
      for (int i = 0; i < 300 && busy_o; i++) @(negedge clk);
      chk("coinc_overrun_count", 32'(ovr_cnt - o0), 32'd0);

      // Reset in the middle of SHIFT, then a clean frame.
      dev_q.push_back(16'hFFFF);
      exp_q.push_back('{f: 16'hFFFF, d: 8'hFF});
      pulse_start(MODE0, 2'd0, 1'b0, e0);
      for (int i = 0; i < 300 && cyc < e0 + 68; i++) @(negedge clk);
      chk("pre_rst_busy", 32'(busy_o), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_cs", 32'(cs_o), 32'hF);
      chk("mid_rst_sck", 32'(sck_o), 32'd0);
      chk("mid_rst_valid", 32'(valid_o), 32'd0);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_frame", 32'(frame_o), 32'd0);
      exp_q.delete();
      dev_q.delete();
      rst = 1'b0;
      ready_i = 1'b1;
      run_frame(MODE1, 2'd0, 16'hC3A5, 8'h1D);
      chk("post_rst_frame", 32'(frame_o), 32'hC3A5);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
